dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The module SHALL take parameter ADDR_W, default 32, as the bus address width.
REQ-002 The module SHALL take parameter TIMEOUT, default 255, as the maximum cycles spent waiting for bus_ack (range 1..255).
REQ-003 Port clk  in  1  the single clock; all state is on its rising edge.
REQ-004 Port rst  in  1  reset; asynchronous, active-low.
REQ-005 Port mem_ren  in  1  MEM-stage load request from the datapath.
REQ-006 Port mem_wen  in  1  MEM-stage store request from the datapath.
REQ-007 Port mem_addr  in  32  byte address, the datapath ALU result.
REQ-008 Port mem_dout  in  32  store data from the datapath.
REQ-009 Port mem_din  out  32  load data returned to the datapath.
REQ-010 Port mem_stall  out  1  asserted means the pipeline holds all stages.
REQ-011 Port bus_req  out  1  bus request strobe.
REQ-012 Port bus_we  out  1  1 for a write cycle, 0 for a read cycle.
REQ-013 Port bus_addr  out  ADDR_W  word-aligned bus address, equal to mem_addr[ADDR_W-1:2] with 2'b00 appended.
REQ-014 Port bus_wdata  out  32  bus write data.
REQ-015 Port bus_ack  in  1  bus completion, one cycle wide.
REQ-016 Port bus_rdata  in  32  bus read data, valid when bus_ack is high.
REQ-017 Port mem_err  out  1  sticky error flag.

Function
REQ-018 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-019 IDLE with (mem_ren|mem_wen)=1 -> BUSY on the next edge, registering addr/wdata/we into bus_addr/bus_wdata/bus_we and setting bus_req=1.
REQ-020 mem_stall SHALL equal (state==IDLE & (mem_ren|mem_wen)) | state==BUSY, purely combinational, so the request cycle itself stalls.
REQ-021 BUSY with bus_ack=1 -> DONE with bus_req=0; for a read, bus_rdata SHALL be captured into mem_din on the same edge.
REQ-022 DONE SHALL last exactly one cycle with mem_stall=0 and mem_ren/mem_wen ignored, so the pipeline advances, then -> IDLE.
REQ-023 An access completed with zero-wait ack (ack in the first BUSY cycle) SHALL stall the pipeline exactly 2 cycles: the IDLE request cycle and one BUSY cycle.
REQ-024 mem_din SHALL hold its last captured value until the next read ack; writes SHALL NOT change it.
REQ-025 mem_ren=mem_wen=1 together SHALL be treated as a write and SHALL set mem_err.
REQ-026 An 8-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-027 When the wait counter reaches TIMEOUT in BUSY, the block SHALL go to DONE, drop bus_req, set mem_err and force mem_din to 32'hDEAD_BEEF for a read.
REQ-028 bus_ack outside BUSY SHALL be ignored.
REQ-029 bus_addr, bus_we and bus_wdata SHALL stay stable while bus_req=1.

Reset
REQ-030 rst=0 SHALL asynchronously force state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, mem_din=0, mem_err=0 and wait counter=0, including mid-BUSY; the aborted access SHALL NOT be retried.
REQ-031 mem_err SHALL clear only on reset.

Configuration
REQ-032 With macro DMEM_ALIGN_CHECK_EN defined, a request with mem_addr[1:0]!=0 SHALL skip BUSY, going IDLE -> DONE with bus_req never asserted, and SHALL set mem_err; mem_din SHALL be unchanged.
REQ-033 Without DMEM_ALIGN_CHECK_EN, mem_addr[1:0] SHALL be silently dropped and the access performed normally.

Verification
REQ-034 Read with ack on the 3rd BUSY cycle: mem_ren=1, addr=0x10, bus_rdata=0x12345678 -> bus_req high 3 cycles, mem_stall high 4 cycles, mem_din=0x12345678 in DONE, mem_err=0.
REQ-035 Back-to-back write then read, zero-wait: store 0xCAFEF00D to 0x20, then load 0x24 -> two bus cycles with bus_we 1 then 0, each access stalling 2 cycles, with one DONE cycle between them.
REQ-036 Timeout with TIMEOUT=4 and no ack: read 0x30 -> DONE after 4 BUSY cycles, mem_din=0xDEADBEEF, mem_err=1 and staying set.
REQ-037 Reset asserted in the 2nd BUSY cycle -> bus_req=0 and mem_stall=0 immediately; after release the block is IDLE and a later ack pulse is ignored.
REQ-038 With DMEM_ALIGN_CHECK_EN, read 0x13 -> bus_req never high, mem_stall high 1 cycle, mem_err=1; without the macro the same read gives bus_addr=0x10.
REQ-039 mem_ren=mem_wen=1 at addr 0x40 -> bus_we=1 and mem_err=1.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data memory controller bridging the pipeline's
// load/store requests to a single-outstanding request/ack bus.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned
// accesses (mem_addr[1:0] != 0) without touching the bus and flag mem_err.
// Without the macro the low address bits are dropped and the access proceeds.
module dmem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_dout,
    output logic [31:0]       mem_din,
    output logic              mem_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value seen in the last BUSY cycle before giving up.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  wait_cnt_reg;
    logic        req;
    logic        misaligned_skip;
    logic        timeout_hit;

    assign req         = mem_ren | mem_wen;
    assign timeout_hit = (wait_cnt_reg == TIMEOUT_LAST);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned_skip = |mem_addr[1:0];
`else
    // Low address bits are intentionally ignored in this build.
    logic unused_addr_lo;
    assign unused_addr_lo  = ^mem_addr[1:0];
    assign misaligned_skip = 1'b0;
`endif

    // Stall covers the request cycle itself plus every cycle waiting on the bus.
    assign mem_stall = ((state_reg == IDLE) && req) || (state_reg == BUSY);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; DONE always lasts one cycle so the pipeline advances.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    state_next = misaligned_skip ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (bus_ack || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus-side registers, wait counter, load data and the sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            mem_din      <= '0;
            mem_err      <= 1'b0;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        // A simultaneous load+store is ambiguous: run it as a
                        // store and flag it.
                        if (mem_ren && mem_wen) begin
                            mem_err <= 1'b1;
                        end
                        if (misaligned_skip) begin
                            mem_err <= 1'b1;
                        end else begin
                            // Address/data/direction latched here stay frozen
                            // for the whole bus cycle.
                            bus_req      <= 1'b1;
                            bus_we       <= mem_wen;
                            bus_addr     <= {mem_addr[ADDR_W-1:2], 2'b00};
                            bus_wdata    <= mem_dout;
                            wait_cnt_reg <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            mem_din <= bus_rdata;
                        end
                    end else if (timeout_hit) begin
                        bus_req <= 1'b0;
                        mem_err <= 1'b1;
                        if (!bus_we) begin
                            mem_din <= TIMEOUT_DATA;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    // DONE: hold everything; requests and stray acks ignored.
                end
            endcase
        end
    end

endmodule
